// File: rtl/switch_port_q_if.sv
// Link bundle for one switch port: ingress handshake, arbiter request/grant
// and egress packet. master = link/arbiter side, slave = switch_port_q.
interface switch_port_q_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8
);
    logic                 valid_in;
    logic                 in_ready;
    logic [NUM_PORTS-1:0] source_in;
    logic [NUM_PORTS-1:0] target_in;
    logic [DATA_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] req_out;
    logic                 gnt_in;
    logic                 valid_out;
    logic [NUM_PORTS-1:0] source_out;
    logic [NUM_PORTS-1:0] target_out;
    logic [DATA_W-1:0]    data_out;

    modport master (
        output valid_in, source_in, target_in, data_in, gnt_in,
        input  in_ready, req_out, valid_out,
        input  source_out, target_out, data_out
    );

    modport slave (
        input  valid_in, source_in, target_in, data_in, gnt_in,
        output in_ready, req_out, valid_out,
        output source_out, target_out, data_out
    );
endinterface

// File: rtl/switch_port_q.sv
// Switch port: ingress packet FIFO plus IDLE/ROUTE/ARB_WAIT/TRANSMIT FSM that
// requests egress ports from the central arbiter and emits each packet.
// Ports: clk, rst_n (async, active low), port (switch_port_q_if.slave:
//   ingress valid/ready/source/target/data, req/gnt, egress valid/src/tgt/data),
//   err_out (illegal/timed-out packet pulse), drop_cnt (saturating count of
//   packets refused while full), fifo_level (current occupancy).
// Optional: define ARB_TIMEOUT_EN to abandon a request after TIMEOUT cycles.
module switch_port_q #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 16,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    switch_port_q_if.slave   port,
    output logic             err_out,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PKT_W = 2 * NUM_PORTS + DATA_W;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ROUTE    = 2'd1;
    localparam logic [1:0] S_ARB_WAIT = 2'd2;
    localparam logic [1:0] S_TRANSMIT = 2'd3;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("switch_port_q: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
    end

    logic [PKT_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_nxt;
    logic                 push;
    logic                 pop;
    logic                 illegal;
    logic [1:0]           state;
    logic [NUM_PORTS-1:0] pkt_src;
    logic [NUM_PORTS-1:0] pkt_tgt;
    logic [DATA_W-1:0]    pkt_data;

    // in_ready is a flop of the occupancy, so a full FIFO refuses a push
    // even in a cycle where the FSM pops.
    assign push = port.valid_in && port.in_ready;
    assign pop  = (state == S_IDLE) && (fifo_level != '0);

    assign illegal = (pkt_tgt == '0) || ((pkt_tgt & pkt_src) != '0);

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {port.source_in, port.target_in, port.data_in};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            port.in_ready <= 1'b1;
            drop_cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level    <= level_nxt;
            port.in_ready <= (level_nxt != LVL_W'(DEPTH));
            if (port.valid_in && !port.in_ready && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pkt_src         <= '0;
            pkt_tgt         <= '0;
            pkt_data        <= '0;
            port.req_out    <= '0;
            port.valid_out  <= 1'b0;
            port.source_out <= '0;
            port.target_out <= '0;
            port.data_out   <= '0;
            err_out         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            port.valid_out <= 1'b0;
            err_out        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {pkt_src, pkt_tgt, pkt_data} <= mem[rd_ptr];
                        state <= S_ROUTE;
                    end
                end
                S_ROUTE: begin
                    if (illegal) begin
                        err_out <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        port.req_out <= pkt_tgt;
                        state        <= S_ARB_WAIT;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                    end
                end
                S_ARB_WAIT: begin
                    // A grant beats a timeout landing in the same cycle.
                    if (port.gnt_in) begin
                        port.req_out    <= '0;
                        port.valid_out  <= 1'b1;
                        port.source_out <= pkt_src;
                        port.target_out <= pkt_tgt;
                        port.data_out   <= pkt_data;
                        state           <= S_TRANSMIT;
`ifdef ARB_TIMEOUT_EN
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        port.req_out <= '0;
                        err_out      <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
`endif
                    end
                end
                S_TRANSMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_port_q.sv
// Directed bench for switch_port_q: vector table of single packets plus
// hand-written FIFO fill, multicast hold, mid-packet reset and timeout runs.
module tb_switch_port_q;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int LW = 3;

    typedef struct {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
        logic [3:0] exp_req;
        logic       exp_err;
        logic       exp_valid;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          err_out;
    logic [CW-1:0] drop_cnt;
    logic [LW-1:0] fifo_level;
    int            checks = 0;
    int            failures = 0;

    switch_port_q_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    switch_port_q #(
        .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(4), .CNT_W(CW), .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port       (bus.slave),
        .err_out    (err_out),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic [3:0] t, input logic [7:0] d);
        bus.valid_in  = v;
        bus.source_in = s;
        bus.target_in = t;
        bus.data_in   = d;
    endtask

    vec_t vecs [6];
    int   n_out;
    int   out_at [8];
    logic [7:0] out_data [8];
    logic [7:0] exp_fill [5];
    int   cnt_bad;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0001, 4'b0100, 8'hA5, 4'b0100, 1'b0, 1'b1};
        vecs[1] = '{4'b0010, 4'b0000, 8'h3C, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{4'b0010, 4'b0010, 8'h5A, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{4'b0001, 4'b1010, 8'h77, 4'b1010, 1'b0, 1'b1};
        vecs[4] = '{4'b1000, 4'b0111, 8'hFF, 4'b0111, 1'b0, 1'b1};
        vecs[5] = '{4'b0100, 4'b1100, 8'h00, 4'b0000, 1'b1, 1'b0};
        exp_fill = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24};

        rst_n = 1'b0;
        bus.gnt_in = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_req", bus.req_out, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        tick;
        tick;

        // single packets, grant tied high: req in cycle 3, valid in cycle 4
        for (int i = 0; i < 6; i++) begin
            bus.gnt_in = 1'b1;
            drive(1'b1, vecs[i].src, vecs[i].tgt, vecs[i].data);
            tick;
            drive(1'b0, 4'h0, 4'h0, 8'h00);
            chk($sformatf("v%0d_c1_valid", i), bus.valid_out, 0);
            tick;
            chk($sformatf("v%0d_c2_req", i), bus.req_out, 0);
            tick;
            chk($sformatf("v%0d_c3_req", i), bus.req_out, vecs[i].exp_req);
            chk($sformatf("v%0d_c3_err", i), err_out, vecs[i].exp_err);
            chk($sformatf("v%0d_c3_valid", i), bus.valid_out, 0);
            tick;
            chk($sformatf("v%0d_c4_valid", i), bus.valid_out, vecs[i].exp_valid);
            chk($sformatf("v%0d_c4_err", i), err_out, 0);
            chk($sformatf("v%0d_c4_req", i), bus.req_out, 0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_src", i), bus.source_out, vecs[i].src);
                chk($sformatf("v%0d_tgt", i), bus.target_out, vecs[i].tgt);
                chk($sformatf("v%0d_data", i), bus.data_out, vecs[i].data);
            end
            tick;
            chk($sformatf("v%0d_c5_valid", i), bus.valid_out, 0);
            chk($sformatf("v%0d_c5_err", i), err_out, 0);
            chk($sformatf("v%0d_level", i), fifo_level, 0);
        end
        bus.gnt_in = 1'b0;

        // head packet parks in ARB_WAIT, then 5 pushes against DEPTH=4
        drive(1'b1, 4'b0001, 4'b0010, 8'h10);
        tick;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        tick;
        tick;
        chk("fill_head_req", bus.req_out, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fill_rdy%0d", k), bus.in_ready, (k < 4) ? 1 : 0);
            drive(1'b1, 4'b0010, 4'b0001, 8'(8'h21 + k));
            tick;
        end
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        chk("fill_drop", drop_cnt, 1);
        chk("fill_level", fifo_level, 4);
        chk("fill_rdy_after", bus.in_ready, 0);
        tick;
        tick;
        chk("fill_hold_req", bus.req_out, 4'b0010);
        chk("fill_hold_valid", bus.valid_out, 0);
        bus.gnt_in = 1'b1;
        n_out = 0;
        for (int c = 0; c < 25; c++) begin
            tick;
            if (bus.valid_out && n_out < 8) begin
                out_at[n_out] = c;
                out_data[n_out] = bus.data_out;
                n_out++;
            end
        end
        chk("drain_count", n_out, 5);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("drain%0d_data", j), out_data[j], exp_fill[j]);
            chk($sformatf("drain%0d_cycle", j), out_at[j], 4 * j);
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_rdy", bus.in_ready, 1);
        chk("drain_drop_hold", drop_cnt, 1);
        bus.gnt_in = 1'b0;
        tick;

        // multicast request held until grant
        drive(1'b1, 4'b0001, 4'b1010, 8'h66);
        tick;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        tick;
        tick;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mc_hold%0d_req", k), bus.req_out, 4'b1010);
            chk($sformatf("mc_hold%0d_valid", k), bus.valid_out, 0);
            tick;
        end
        bus.gnt_in = 1'b1;
        tick;
        chk("mc_valid", bus.valid_out, 1);
        chk("mc_tgt", bus.target_out, 4'b1010);
        chk("mc_data", bus.data_out, 8'h66);
        chk("mc_req_clr", bus.req_out, 0);
        bus.gnt_in = 1'b0;
        tick;
        chk("mc_valid_end", bus.valid_out, 0);

        // reset while in ARB_WAIT with two packets queued
        drive(1'b1, 4'b0001, 4'b0100, 8'h31);
        tick;
        drive(1'b1, 4'b0001, 4'b0100, 8'h32);
        tick;
        drive(1'b1, 4'b0001, 4'b0100, 8'h33);
        tick;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        chk("rq_req", bus.req_out, 4'b0100);
        chk("rq_level", fifo_level, 2);
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("rq_rst_req", bus.req_out, 0);
        chk("rq_rst_valid", bus.valid_out, 0);
        chk("rq_rst_level", fifo_level, 0);
        chk("rq_rst_rdy", bus.in_ready, 1);
        tick;
        rst_n = 1'b1;
        bus.gnt_in = 1'b1;
        cnt_bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick;
            if (bus.valid_out || bus.req_out != 4'b0000) cnt_bad++;
        end
        chk("rq_no_output", cnt_bad, 0);
        chk("rq_level_after", fifo_level, 0);
        bus.gnt_in = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // timeout: err_out 16 cycles after ARB_WAIT entry
        drive(1'b1, 4'b0001, 4'b0100, 8'h41);
        tick;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        tick;
        tick;
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("to%0d_err", k), err_out, (k == 16) ? 1 : 0);
            chk($sformatf("to%0d_req", k), bus.req_out,
                (k < 16) ? 4'b0100 : 4'b0000);
            tick;
        end
        // grant in the timeout cycle wins
        drive(1'b1, 4'b0001, 4'b0100, 8'h42);
        tick;
        drive(1'b0, 4'h0, 4'h0, 8'h00);
        tick;
        tick;
        for (int k = 0; k < 15; k++) tick;
        bus.gnt_in = 1'b1;
        tick;
        chk("tog_valid", bus.valid_out, 1);
        chk("tog_err", err_out, 0);
        chk("tog_data", bus.data_out, 8'h42);
        bus.gnt_in = 1'b0;
        tick;
        chk("tog_err_after", err_out, 0);
        chk("tog_valid_after", bus.valid_out, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
